// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with an input FIFO.
// Character width, parity mode and stop-bit count are fixed at elaboration.
// Producers push through a valid/ready handshake; queued characters are
// sent back-to-back, with a single high DONE cycle between frames.
module uart_tx_cfg #(
    parameter int CLK_FRE    = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          uclk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int BPS_CNT = CLK_FRE / BAUD;
    localparam int BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int BIT_W   = $clog2(DATA_BITS + 1);
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic              PAR_ODD   = (PARITY == 2);

    // Elaboration-time parameter legality checks
    if (BPS_CNT < 2) begin : g_chk_bps
        $error("uart_tx_cfg: CLK_FRE/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_DONE   = 6'b100000
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];

    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  baud_end;
    logic [BAUD_W-1:0]     baud_inc;
    logic [DATA_BITS-1:0]  head;

    assign wr_addr  = wr_ptr_q[AW-1:0];
    assign rd_addr  = rd_ptr_q[AW-1:0];
    assign full     = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign tx_ready = !full;
    assign fifo_cnt = wr_ptr_q - rd_ptr_q;
    assign push     = tx_valid && !full;
    assign head     = mem_q[rd_addr];

    assign baud_end = (baud_q == BAUD_LAST);
    assign baud_inc = baud_end ? '0 : baud_q + BAUD_W'(1);

    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = (state_q == ST_DONE);

    // Next-state logic: frame sequencing, baud/bit/stop counters, FIFO pop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                baud_d = '0;
                if (!empty) begin
                    // Parity comes from the whole character now, before shifting
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (^head) ^ PAR_ODD;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                baud_d = baud_inc;
                if (baud_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = baud_inc;
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                baud_d = baud_inc;
                if (baud_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                baud_d = baud_inc;
                if (baud_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                stop_d  = 1'b0;
            end
        endcase
    end

    // FIFO pointer update from the push/pop strobes
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Serial line decoded from registered state only
    always_comb begin
        txd = 1'b1;
        case (state_q)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = shift_q[0];
            ST_PARITY: txd = par_q;
            default:   txd = 1'b1;
        endcase
    end

    // Control and datapath registers with synchronous active-low reset
    always_ff @(posedge uclk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge uclk) begin
        if (rst_n && push) begin
            mem_q[wr_addr] <= tx_data;
        end
    end

    // A stalled producer must hold its offer until it is taken
    property p_hold_offer;
        @(posedge uclk) disable iff (!rst_n)
            (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data));
    endproperty
    a_hold_offer: assert property (p_hold_offer);
    c_hold_offer: cover property (p_hold_offer);

    // tx_done lasts exactly one cycle
    a_done_pulse: assert property (@(posedge uclk) disable iff (!rst_n)
        tx_done |=> !tx_done);

endmodule
